// File: rtl/runway_traffic_controller_if.sv
// Request, weather and grant/status signals between the runway controller and its environment.
// The slave modport is the controller's view; the master modport drives requests and weather.
interface runway_traffic_controller_if #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned ID_W        = 4
);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic             landing_req;
  logic [ID_W-1:0]  landing_id;
  logic             takeoff_req;
  logic [ID_W-1:0]  takeoff_id;
  logic             severe_weather;
  logic             emergency_landing_alert;
  logic             grant_valid;
  logic [ID_W-1:0]  grant_id;
  logic             grant_is_landing;
  logic             runway_busy;
  logic [CNT_W-1:0] landing_count;
  logic [CNT_W-1:0] takeoff_count;
  logic             req_dropped;
  logic [1:0]       rtc_state;

  modport master (
    output landing_req, landing_id, takeoff_req, takeoff_id,
    output severe_weather, emergency_landing_alert,
    input  grant_valid, grant_id, grant_is_landing, runway_busy,
    input  landing_count, takeoff_count, req_dropped, rtc_state
  );

  modport slave (
    input  landing_req, landing_id, takeoff_req, takeoff_id,
    input  severe_weather, emergency_landing_alert,
    output grant_valid, grant_id, grant_is_landing, runway_busy,
    output landing_count, takeoff_count, req_dropped, rtc_state
  );
endinterface

// File: rtl/runway_traffic_controller.sv
// Single-runway arbiter: landing and takeoff FIFOs, weather-gated takeoffs, bounded landing
// bursts while a takeoff waits, and a fixed occupancy time per grant.
module runway_traffic_controller #(
  parameter int unsigned QUEUE_DEPTH   = 4,
  parameter int unsigned ID_W          = 4,
  parameter int unsigned OCCUPY_CYCLES = 3,
  parameter int unsigned LAND_BURST    = 3
) (
  input logic                       CLK,
  input logic                       RST,
  runway_traffic_controller_if.slave bus
);
  localparam int unsigned PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned OCC_W   = $clog2(OCCUPY_CYCLES + 1);
  localparam int unsigned BURST_W = $clog2(LAND_BURST + 1);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StLanding = 2'b01,
    StTakeoff = 2'b10,
    StBad     = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               grant_valid_q, grant_valid_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               grant_land_q, grant_land_d;
  logic               busy_q, busy_d;
  logic               dropped_q, dropped_d;

  logic [ID_W-1:0]  land_mem [QUEUE_DEPTH];
  logic [ID_W-1:0]  tko_mem  [QUEUE_DEPTH];
  logic [PTR_W-1:0] land_rptr_q, land_wptr_q, tko_rptr_q, tko_wptr_q;
  logic [CNT_W-1:0] land_cnt_q, land_cnt_d, tko_cnt_q, tko_cnt_d;

  logic land_empty, land_full, tko_empty, tko_full, tko_eligible;
  logic land_push, land_pop, tko_push, tko_pop;

  assign land_empty   = (land_cnt_q == '0);
  assign land_full    = (land_cnt_q == CNT_W'(QUEUE_DEPTH));
  assign tko_empty    = (tko_cnt_q == '0);
  assign tko_full     = (tko_cnt_q == CNT_W'(QUEUE_DEPTH));
  assign tko_eligible = !tko_empty && !bus.severe_weather && !bus.emergency_landing_alert;

  // A full FIFO still takes a push when its head leaves on the same edge.
  assign land_push = bus.landing_req && (!land_full || land_pop);
  assign tko_push  = bus.takeoff_req && !bus.emergency_landing_alert && (!tko_full || tko_pop);
  assign dropped_d = (bus.landing_req && !land_push) || (bus.takeoff_req && !tko_push);

  always_comb begin
    state_d       = state_q;
    occ_d         = occ_q;
    burst_d       = burst_q;
    land_pop      = 1'b0;
    tko_pop       = 1'b0;
    grant_valid_d = 1'b0;
    grant_id_d    = grant_id_q;
    grant_land_d  = grant_land_q;
    case (state_q)
      StIdle: begin
        if (!land_empty && (!tko_eligible || burst_q < BURST_W'(LAND_BURST))) begin
          land_pop      = 1'b1;
          grant_valid_d = 1'b1;
          grant_id_d    = land_mem[land_rptr_q];
          grant_land_d  = 1'b1;
          occ_d         = OCC_W'(OCCUPY_CYCLES - 1);
          state_d       = StLanding;
          if (burst_q != BURST_W'(LAND_BURST)) burst_d = burst_q + 1'b1;
        end else if (tko_eligible) begin
          tko_pop       = 1'b1;
          grant_valid_d = 1'b1;
          grant_id_d    = tko_mem[tko_rptr_q];
          grant_land_d  = 1'b0;
          occ_d         = OCC_W'(OCCUPY_CYCLES - 1);
          state_d       = StTakeoff;
          burst_d       = '0;
        end else if (land_empty) begin
          burst_d = '0;
        end
      end
      StLanding, StTakeoff: begin
        if (occ_q == '0) state_d = StIdle;
        else             occ_d   = occ_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_d = (state_d == StLanding) || (state_d == StTakeoff);

  always_comb begin
    land_cnt_d = land_cnt_q;
    if (land_push && !land_pop)      land_cnt_d = land_cnt_q + 1'b1;
    else if (!land_push && land_pop) land_cnt_d = land_cnt_q - 1'b1;
    tko_cnt_d = tko_cnt_q;
    if (tko_push && !tko_pop)        tko_cnt_d = tko_cnt_q + 1'b1;
    else if (!tko_push && tko_pop)   tko_cnt_d = tko_cnt_q - 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= StIdle;
      occ_q         <= '0;
      burst_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      grant_land_q  <= 1'b0;
      busy_q        <= 1'b0;
      dropped_q     <= 1'b0;
      land_rptr_q   <= '0;
      land_wptr_q   <= '0;
      land_cnt_q    <= '0;
      tko_rptr_q    <= '0;
      tko_wptr_q    <= '0;
      tko_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      occ_q         <= occ_d;
      burst_q       <= burst_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      grant_land_q  <= grant_land_d;
      busy_q        <= busy_d;
      dropped_q     <= dropped_d;
      land_cnt_q    <= land_cnt_d;
      tko_cnt_q     <= tko_cnt_d;
      if (land_push) land_wptr_q <= land_wptr_q + 1'b1;
      if (land_pop)  land_rptr_q <= land_rptr_q + 1'b1;
      if (tko_push)  tko_wptr_q  <= tko_wptr_q + 1'b1;
      if (tko_pop)   tko_rptr_q  <= tko_rptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (land_push) land_mem[land_wptr_q] <= bus.landing_id;
    if (tko_push)  tko_mem[tko_wptr_q]   <= bus.takeoff_id;
  end

  assign bus.grant_valid      = grant_valid_q;
  assign bus.grant_id         = grant_id_q;
  assign bus.grant_is_landing = grant_land_q;
  assign bus.runway_busy      = busy_q;
  assign bus.landing_count    = land_cnt_q;
  assign bus.takeoff_count    = tko_cnt_q;
  assign bus.req_dropped      = dropped_q;
  assign bus.rtc_state        = state_q;
endmodule

// File: tb/tb_runway_traffic_controller.sv
// Directed bench for runway_traffic_controller: per-cycle vector table plus hand-written
// sequences for weather hold, burst fairness with a full queue, and asynchronous reset.
module tb_runway_traffic_controller;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  runway_traffic_controller_if #(.QUEUE_DEPTH(4), .ID_W(4)) bus ();

  runway_traffic_controller #(
    .QUEUE_DEPTH  (4),
    .ID_W         (4),
    .OCCUPY_CYCLES(3),
    .LAND_BURST   (3)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       lreq;
    logic [3:0] lid;
    logic       treq;
    logic [3:0] tid;
    logic       sw;
    logic       em;
    logic       gv;
    logic [3:0] gid;
    logic       gl;
    logic       busy;
    logic [2:0] lc;
    logic [2:0] tc;
    logic       drop;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[11];
  logic [4:0] grants_q[$];
  logic [4:0] exp_grants[9];

  always @(negedge CLK) begin
    if (RST && bus.grant_valid) grants_q.push_back({bus.grant_is_landing, bus.grant_id});
  end

  function automatic vec_t mk(int lreq, int lid, int treq, int tid, int sw, int em,
                              int gv, int gid, int gl, int busy, int lc, int tc,
                              int drop, int st);
    vec_t v;
    v.lreq = lreq[0]; v.lid = lid[3:0]; v.treq = treq[0]; v.tid = tid[3:0];
    v.sw = sw[0]; v.em = em[0]; v.gv = gv[0]; v.gid = gid[3:0]; v.gl = gl[0];
    v.busy = busy[0]; v.lc = lc[2:0]; v.tc = tc[2:0]; v.drop = drop[0]; v.st = st[1:0];
    return v;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic lreq, input logic [3:0] lid, input logic treq,
                       input logic [3:0] tid, input logic sw, input logic em);
    bus.landing_req = lreq; bus.landing_id = lid;
    bus.takeoff_req = treq; bus.takeoff_id = tid;
    bus.severe_weather = sw; bus.emergency_landing_alert = em;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " grant_valid"}, bus.grant_valid, 0);
    check({tag, " grant_id"}, bus.grant_id, 0);
    check({tag, " grant_is_landing"}, bus.grant_is_landing, 0);
    check({tag, " runway_busy"}, bus.runway_busy, 0);
    check({tag, " landing_count"}, bus.landing_count, 0);
    check({tag, " takeoff_count"}, bus.takeoff_count, 0);
    check({tag, " req_dropped"}, bus.req_dropped, 0);
    check({tag, " rtc_state"}, bus.rtc_state, 0);
  endtask

  initial begin
    // Single landing (id 5), then emergency rejection of takeoff id 2 while landing 6 proceeds.
    vecs[0]  = mk(1, 5, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0,  1, 5, 1, 1, 0, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0,  0, 5, 1, 1, 0, 0, 0, 1);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0,  0, 5, 1, 1, 0, 0, 0, 1);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0,  0, 5, 1, 0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 1, 2, 0, 1,  0, 5, 1, 0, 0, 0, 1, 0);
    vecs[6]  = mk(1, 6, 0, 0, 0, 1,  0, 5, 1, 0, 1, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 1,  1, 6, 1, 1, 0, 0, 0, 1);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0,  0, 6, 1, 1, 0, 0, 0, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0,  0, 6, 1, 1, 0, 0, 0, 1);
    vecs[10] = mk(0, 0, 0, 0, 0, 0,  0, 6, 1, 0, 0, 0, 0, 0);

    exp_grants = '{5'h11, 5'h12, 5'h13, 5'h0A, 5'h14, 5'h15, 5'h16, 5'h17, 5'h19};

    do_reset();
    check_all_zero("reset");

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].lreq, vecs[i].lid, vecs[i].treq, vecs[i].tid, vecs[i].sw, vecs[i].em);
      step();
      check($sformatf("v%0d grant_valid", i), bus.grant_valid, vecs[i].gv);
      check($sformatf("v%0d grant_id", i), bus.grant_id, vecs[i].gid);
      check($sformatf("v%0d grant_is_landing", i), bus.grant_is_landing, vecs[i].gl);
      check($sformatf("v%0d runway_busy", i), bus.runway_busy, vecs[i].busy);
      check($sformatf("v%0d landing_count", i), bus.landing_count, vecs[i].lc);
      check($sformatf("v%0d takeoff_count", i), bus.takeoff_count, vecs[i].tc);
      check($sformatf("v%0d req_dropped", i), bus.req_dropped, vecs[i].drop);
      check($sformatf("v%0d rtc_state", i), bus.rtc_state, vecs[i].st);
    end

    // Weather block: takeoff 9 waits under severe weather, then goes on the first clear edge.
    do_reset();
    drive(1'b0, 4'h0, 1'b1, 4'h9, 1'b1, 1'b0);
    step();
    bus.takeoff_req = 1'b0;
    check("wx pushed takeoff_count", bus.takeoff_count, 1);
    for (int i = 0; i < 9; i++) begin
      step();
      check("wx hold grant_valid", bus.grant_valid, 0);
      check("wx hold takeoff_count", bus.takeoff_count, 1);
    end
    bus.severe_weather = 1'b0;
    step();
    check("wx release grant_valid", bus.grant_valid, 1);
    check("wx release grant_id", bus.grant_id, 9);
    check("wx release grant_is_landing", bus.grant_is_landing, 0);
    check("wx release rtc_state", bus.rtc_state, 2);
    check("wx release takeoff_count", bus.takeoff_count, 0);

    // Asynchronous reset in the middle of the takeoff occupancy, with a landing queued.
    drive(1'b1, 4'hC, 1'b0, 4'h0, 1'b0, 1'b0);
    step();
    bus.landing_req = 1'b0;
    check("arst pre landing_count", bus.landing_count, 1);
    check("arst pre rtc_state", bus.rtc_state, 2);
    #3;
    RST = 1'b0;
    #1;
    check_all_zero("arst");
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("arst after grant_valid", bus.grant_valid, 0);
      check("arst after rtc_state", bus.rtc_state, 0);
      check("arst after landing_count", bus.landing_count, 0);
    end

    // Burst fairness: 3 landings, the takeoff, then the rest; queue fills during the takeoff.
    do_reset();
    grants_q.delete();
    drive(1'b1, 4'h1, 1'b1, 4'hA, 1'b0, 1'b0);
    step();
    bus.takeoff_req = 1'b0;
    check("burst e0 takeoff_count", bus.takeoff_count, 1);
    bus.landing_id = 4'h2;
    step();
    check("burst e1 grant_id", bus.grant_id, 1);
    check("burst e1 grant_valid", bus.grant_valid, 1);
    bus.landing_id = 4'h3;
    step();
    bus.landing_id = 4'h4;
    step();
    check("burst e3 landing_count", bus.landing_count, 3);
    bus.landing_req = 1'b0;
    repeat (9) step();
    bus.landing_req = 1'b1;
    bus.landing_id  = 4'h5;
    step();
    check("burst e13 grant_valid", bus.grant_valid, 1);
    check("burst e13 grant_id", bus.grant_id, 4'hA);
    check("burst e13 grant_is_landing", bus.grant_is_landing, 0);
    bus.landing_id = 4'h6;
    step();
    bus.landing_id = 4'h7;
    step();
    check("full landing_count", bus.landing_count, 4);
    check("full req_dropped before", bus.req_dropped, 0);
    bus.landing_id = 4'h8;
    step();
    check("full req_dropped", bus.req_dropped, 1);
    check("full landing_count hold", bus.landing_count, 4);
    bus.landing_req = 1'b0;
    step();
    check("full req_dropped clears", bus.req_dropped, 0);
    check("burst e17 grant_id", bus.grant_id, 4);
    repeat (20) step();
    drive(1'b1, 4'h9, 1'b0, 4'h0, 1'b0, 1'b0);
    step();
    bus.landing_req = 1'b0;
    repeat (6) step();
    check("burst grant total", grants_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < grants_q.size())
        check($sformatf("burst grant %0d", i), grants_q[i], exp_grants[i]);
      else
        check($sformatf("burst grant %0d missing", i), 5'h1F, exp_grants[i]);
    end
    check("burst end landing_count", bus.landing_count, 0);
    check("burst end rtc_state", bus.rtc_state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/runway_traffic_controller.md
# runway_traffic_controller

Downstream consumer of the environmental control stage's `severe_weather` and `emergency_landing_alert` flags. It queues landing and takeoff requests from approaching and departing aircraft in two FIFOs. It grants the single runway to one aircraft at a time under weather-dependent rules and holds the runway occupied for a fixed time. It sits between the weather monitor and the top-level airport controller outputs.

## Interface
- `QUEUE_DEPTH`, 4: entries per FIFO; a power of two, 2 or greater.
- `ID_W`, 4: aircraft ID width.
- `OCCUPY_CYCLES`, 3: runway-busy cycles per grant; 1 or greater.
- `LAND_BURST`, 3: maximum consecutive landings while a takeoff is waiting and eligible.
- `CLK` in 1: system clock; rising edge.
- `RST` in 1: reset. It is asynchronous and active-low.
- `landing_req` in 1: push a landing request this cycle.
- `landing_id` in ID_W: ID of the landing aircraft.
- `takeoff_req` in 1: push a takeoff request this cycle.
- `takeoff_id` in ID_W: ID of the departing aircraft.
- `severe_weather` in 1: driven by the weather stage; blocks takeoff grants.
- `emergency_landing_alert` in 1: driven by the weather stage; blocks and rejects takeoffs.
- `grant_valid` out 1: one-cycle pulse that issues a runway grant.
- `grant_id` out ID_W: ID of the granted aircraft; holds its value until the next grant.
- `grant_is_landing` out 1: 1 for a landing grant, 0 for a takeoff grant; holds its value like `grant_id`.
- `runway_busy` out 1: runway occupied.
- `landing_count` out clog2(QUEUE_DEPTH)+1: landing queue occupancy.
- `takeoff_count` out clog2(QUEUE_DEPTH)+1: takeoff queue occupancy.
- `req_dropped` out 1: one-cycle pulse when any request is rejected this cycle.
- `rtc_state` out 2: FSM state.

## Operation
- Reset (`RST`=0, asynchronous): all outputs go to 0, both FIFOs are emptied, the burst counter and the occupancy counter are cleared, and `rtc_state`=IDLE. Reset mid-occupancy abandons the grant.
- **FIFOs:** circular buffers with a read pointer, a write pointer and a count. Pointers wrap modulo QUEUE_DEPTH.
- **Push:**
  - A push into a non-full FIFO is accepted.
  - A push into a full FIFO is accepted only if the same FIFO pops in the same cycle; otherwise it is dropped.
  - Simultaneous push and pop on one FIFO leaves the count unchanged.
  - A takeoff push while `emergency_landing_alert`=1 is always dropped.
- **`req_dropped`:** high in any cycle where a landing push, a takeoff push, or both are dropped.
- **FSM states** (encodings): IDLE=2'b00, LANDING=2'b01, TAKEOFF=2'b10. Encoding 2'b11 is illegal and returns to IDLE on the next edge with no grant.
- **Takeoff eligibility:** takeoff queue non-empty AND `severe_weather`=0 AND `emergency_landing_alert`=0.
- **IDLE decision**, evaluated on the queue contents and weather inputs sampled at the edge:
  1. If the landing queue is non-empty and (takeoff is not eligible OR burst count < LAND_BURST): grant a landing, pop the landing FIFO, increment the burst count, and go to LANDING.
  2. Otherwise, if takeoff is eligible: grant a takeoff, pop the takeoff FIFO, clear the burst count, and go to TAKEOFF.
  3. Otherwise, stay in IDLE.
- **Burst count:** also cleared whenever the landing queue is empty in IDLE. It saturates at LAND_BURST.
- **On a grant:**
  - `grant_valid`=1 for exactly one cycle.
  - `grant_id` = the popped head entry.
  - `grant_is_landing` set to 1 for a landing, 0 for a takeoff.
  - The occupancy counter loads OCCUPY_CYCLES-1.
- **LANDING / TAKEOFF:**
  - `runway_busy`=1.
  - The counter decrements each cycle; at 0 the FSM returns to IDLE.
  - Weather changes during occupancy do not abort an in-progress takeoff.
- Weather inputs are used as sampled each cycle. This block adds no filtering.

## Timing
- All outputs are registered.
- A request applied before edge k is in the FIFO after edge k.
- Earliest grant: with an empty runway and the FSM in IDLE, `grant_valid` rises after edge k+1. Latency is 2 cycles from the request cycle.
- `runway_busy` is high for exactly OCCUPY_CYCLES cycles, starting in the grant cycle.
- IDLE lasts at least one cycle between grants, so the back-to-back grant period is OCCUPY_CYCLES+1 cycles (4 at defaults).
- `req_dropped` is high in the cycle after the rejected request's edge.
- Counts update on the same edge as the push or pop.

## Test plan
- **Reset and single landing:** release reset, then `landing_req`=1 with id 5 for one cycle. Required response: `grant_valid` pulses 2 cycles later with `grant_id`=5 and `grant_is_landing`=1; `runway_busy` is high for 3 cycles; `rtc_state` sequence is 00, 01, 01, 01, 00.
- **Weather block:** push takeoff id 9 with `severe_weather`=1 held for 10 cycles. Required response: no grant while it is held and `takeoff_count`=1. Drop `severe_weather`: a takeoff grant with `grant_id`=9 follows 1 cycle later.
- **Emergency rejection:** `emergency_landing_alert`=1 and `takeoff_req` pulsed with id 2. Required response: `req_dropped`=1 for one cycle, `takeoff_count` stays 0, and landings continue to be granted.
- **FIFO full and wrap:** push 5 landings (ids 1–5) on consecutive cycles while the runway is busy. Required response: id 5 is dropped via `req_dropped`; later grants come out in order 1, 2, 3, 4; a further push after pointer wrap is granted correctly.
- **Burst fairness:** fill the landing queue with 4 entries and the takeoff queue with 1 entry under clear weather. Required response: grant order is 3 landings, then the takeoff, then the final landing.
- **Asynchronous reset mid-occupancy:** drive `RST`=0 in the middle of a TAKEOFF occupancy between clock edges. Required response: outputs, counts and `rtc_state` go to 0 immediately, and no grant follows after release.
